cpu_step_ctrl: RTL
==================

// Module: cpu_step_ctrl
// PURPOSE
//  Board-side execution controller for the single-cycle CPU under DESim and on DE-series hardware.
//  Debounces two pushbuttons and generates a one-cycle CPU clock enable in four modes:
//  - single step
//  - N-step burst
//  - free run
//  - idle
//  Also counts issued steps and drives NUM_HEX seven-segment digits from a debug word.
//  Sits between the board pins (KEY/SW/HEX) and the CPU top, replacing direct KEY-clocking of the core.
// PARAMETERS
//  DEBOUNCE_CYCLES  4    consecutive stable samples required to accept a key level change (>=1)
//  RUN_DIV          16   cycles between cpu_en pulses in RUN/BURST (>=2)
//  NUM_HEX          6    number of 7-seg digits driven (1..8)
//  BURST_W          8    width of burst length input
//  CNT_W            16   width of step counter
// PORTS
//  CLOCK_50     in   1            system clock, all logic rising-edge
//  resetn       in   1            asynchronous active-low reset
//  key_step     in   1            raw pushbutton, active-low (0 = pressed), asynchronous
//  key_mode     in   1            raw pushbutton, active-low, asynchronous
//  burst_len    in   BURST_W      steps per burst; 0 selects single step; sampled on step event
//  dbg_data     in   4*NUM_HEX    debug word for display; nibble i feeds digit i
//  cpu_en       out  1            one-cycle CPU clock enable
//  mode         out  2            state: 0 IDLE, 1 STEP, 2 RUN, 3 BURST
//  busy         out  1            high in STEP, RUN or BURST
//  step_count   out  CNT_W        total cpu_en pulses issued since reset
//  hex_out      out  7*NUM_HEX    active-low segments; digit i at [7i+6:7i]; bit0=a .. bit6=g
// BEHAVIOUR
//  Reset (async, resetn=0): cpu_en=0, mode=IDLE, busy=0, step_count=0, hex_out all 1s (blank).
//   Synchronisers and debounced levels are forced to 1 (released); divider=0; remaining=0.
//   Asserting reset mid-burst or mid-run stops pulses the same edge; no pulse completes after reset.
//  Debounce (per key):
//   - 2-FF synchroniser, then a stability counter.
//   - The debounced level takes the synced value after DEBOUNCE_CYCLES consecutive equal differing samples.
//   - A glitch shorter than that resets the counter.
//   - press event = one-cycle pulse on a debounced 1->0 transition; releases generate no event.
//   - Latency: raw held low from cycle 0 gives the event at cycle 2+DEBOUNCE_CYCLES.
//  FSM (evaluated on the event cycle; a mode event and a step event in the same cycle: mode wins, step dropped):
//   IDLE : mode_ev -> RUN.
//          step_ev with burst_len==0 -> STEP.
//          step_ev with burst_len!=0 -> BURST, remaining=burst_len.
//   STEP : cpu_en=1 for exactly this one cycle -> IDLE next cycle. Events in this cycle are ignored.
//   RUN  : divider counts 0..RUN_DIV-1 from 0 on entry; cpu_en=1 on the cycle divider==RUN_DIV-1, then wraps.
//          mode_ev -> IDLE, with no pulse on that cycle. step_ev is ignored.
//   BURST: same divider pacing as RUN; each pulse decrements remaining; the pulse taking remaining to 0 returns to IDLE next cycle.
//          mode_ev aborts to IDLE with no further pulse. step_ev is ignored. burst_len changes during a burst have no effect.
//  First pulse lands RUN_DIV cycles after entry into RUN/BURST; STEP pulses 1 cycle after the event.
//  mode, busy and cpu_en are registered outputs; cpu_en is never high for 2 consecutive cycles when RUN_DIV>=2.
//  step_count increments on every cycle with cpu_en=1 and wraps from 2^CNT_W-1 to 0.
//  Display:
//   - hex_out is registered with 1-cycle latency from dbg_data.
//   - Segment encoding: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000
//     8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110 (bits g..a).
// TESTING
//  Reset: hold resetn=0 -> cpu_en=0, mode=0, step_count=0, hex_out all 1; release -> unchanged until a key event.
//  Debounce: key_step low for 3 cycles then high, DEBOUNCE_CYCLES=4 -> no event, mode stays 0.
//   Held low 10 cycles -> exactly one cpu_en pulse at cycle 7 (event at 6, STEP pulse +1), step_count=1.
//  Burst: burst_len=5, RUN_DIV=16, step press -> mode=3; 5 pulses spaced exactly 16 cycles apart; mode=0 after the 5th; step_count=5.
//  Run/abort: mode press -> RUN, pulses every 16 cycles. Second mode press -> IDLE, no further pulses.
//   Same-cycle mode+step events from IDLE -> RUN, no STEP pulse.
//  Display + wrap: dbg_data=24'h0123AF -> next cycle digits 0..5 = F,A,3,2,1,0 encodings.
//   step_count preset by 65536 pulses (CNT_W=16) -> wraps to 0.
//  Reset mid-burst: burst_len=200, assert resetn=0 after 3 pulses -> cpu_en=0 immediately, mode=0, step_count=0.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
// Board-side CPU execution controller: debounced keys drive a one-cycle cpu_en
// in STEP / BURST / RUN modes, with a wrapping step counter and a 7-seg display.

module cpu_step_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic press_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1_q, sync2_q, level_q, press_q;
    logic [CW-1:0] cnt_q;

    // Level flips only after DEBOUNCE_CYCLES consecutive differing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q != level_q) begin
                if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                    press_q <= ~sync2_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign press_o = press_q;
endmodule

module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RUN_DIV         = 16,
    parameter int NUM_HEX         = 6,
    parameter int BURST_W         = 8,
    parameter int CNT_W           = 16
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    input  logic                 key_step,
    input  logic                 key_mode,
    input  logic [BURST_W-1:0]   burst_len,
    input  logic [4*NUM_HEX-1:0] dbg_data,
    output logic                 cpu_en,
    output logic [1:0]           mode,
    output logic                 busy,
    output logic [CNT_W-1:0]     step_count,
    output logic [7*NUM_HEX-1:0] hex_out
);
    localparam int DW = $clog2(RUN_DIV);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STEP  = 2'd1,
        S_RUN   = 2'd2,
        S_BURST = 2'd3
    } state_t;

    logic step_ev, mode_ev;

    cpu_step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk(CLOCK_50), .rst_n(resetn), .key_i(key_step), .press_o(step_ev)
    );
    cpu_step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk(CLOCK_50), .rst_n(resetn), .key_i(key_mode), .press_o(mode_ev)
    );

    state_t               state_q, state_d;
    logic [DW-1:0]        div_q, div_d;
    logic [BURST_W-1:0]   rem_q, rem_d;
    logic                 en_q, en_d;
    logic                 busy_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [7*NUM_HEX-1:0] hex_q, hex_d;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Mode event is tested before step event so a simultaneous pair enters RUN.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        rem_d   = rem_q;
        en_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (mode_ev) begin
                    state_d = S_RUN;
                end else if (step_ev) begin
                    if (burst_len == '0) begin
                        state_d = S_STEP;
                        en_d    = 1'b1;
                    end else begin
                        state_d = S_BURST;
                        rem_d   = burst_len;
                    end
                end
            end
            S_STEP: state_d = S_IDLE;
            S_RUN: begin
                if (mode_ev) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                end else if (div_q == DW'(RUN_DIV - 1)) begin
                    en_d  = 1'b1;
                    div_d = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                // The last pulse is shown in BURST; IDLE follows one cycle later.
                if (mode_ev || (en_q && rem_q == '0)) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                    rem_d   = '0;
                end else if (div_q == DW'(RUN_DIV - 1)) begin
                    en_d  = 1'b1;
                    div_d = '0;
                    rem_d = rem_q - 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, en_d};
        hex_d = '1;
        for (int i = 0; i < NUM_HEX; i++) begin
            hex_d[7*i +: 7] = seg7(dbg_data[4*i +: 4]);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            rem_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            hex_q   <= '1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            en_q    <= en_d;
            busy_q  <= (state_d != S_IDLE);
            cnt_q   <= cnt_d;
            hex_q   <= hex_d;
        end
    end

    assign cpu_en     = en_q;
    assign mode       = state_q;
    assign busy       = busy_q;
    assign step_count = cnt_q;
    assign hex_out    = hex_q;
endmodule
